// File: rtl/csr_avalon_initiator.sv
// Bridges a valid/ready CSR command/response pair onto an Avalon-MM host port, one access at a time.
// Latency: strobe the cycle after acceptance, response the cycle after completion; rsp_ready stalls RESP.
// Optional abort of accesses stuck under waitrequest when CSR_INITIATOR_TIMEOUT_EN is defined.
module csr_avalon_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        csr_clk_clk,
    input  logic        csr_clk_reset_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_address,
    input  logic [31:0] cmd_writedata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_readdata,
    output logic        rsp_error,
    output logic [15:0] master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic [31:0] master_readdata,
    input  logic        master_waitrequest
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        is_write;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        strobe;
    logic        done;
    logic        abort;

    assign strobe = (state == ACCESS);
    assign done   = strobe && !master_waitrequest;

`ifdef CSR_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;

    // Abort on the last allowed stalled cycle; a late grant on that cycle still wins via done.
    assign abort = strobe && master_waitrequest && (to_cnt == TO_LAST);

    always_ff @(posedge csr_clk_clk) begin
        if (csr_clk_reset_reset) begin
            to_cnt <= '0;
        end else if (state != ACCESS) begin
            to_cnt <= '0;
        end else if (master_waitrequest) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge csr_clk_clk) begin
        if (csr_clk_reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid)      state_nxt = ACCESS;
            ACCESS:  if (done || abort)  state_nxt = RESP;
            RESP:    if (rsp_ready)      state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge csr_clk_clk) begin
        if (csr_clk_reset_reset) begin
            is_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                is_write <= cmd_write;
                addr_q   <= cmd_address;
                wdata_q  <= cmd_writedata;
            end
            if (done) begin
                rdata_q <= is_write ? 32'h0 : master_readdata;
                err_q   <= 1'b0;
            end else if (abort) begin
                rdata_q <= 32'hDEADC0DE;
                err_q   <= 1'b1;
            end
        end
    end

    assign cmd_ready        = (state == IDLE);
    assign rsp_valid        = (state == RESP);
    assign rsp_readdata     = rdata_q;
    assign rsp_error        = err_q;
    assign master_read      = strobe && !is_write;
    assign master_write     = strobe && is_write;
    assign master_address   = addr_q;
    assign master_writedata = wdata_q;

endmodule

// File: tb/tb_csr_avalon_initiator.sv
// Randomized and directed transactions against a transaction-level model of the CSR initiator.
// Define CSR_INITIATOR_TIMEOUT_EN at build time to exercise the abort path.
module tb_csr_avalon_initiator;

    localparam int TO     = 8;
    localparam int BUDGET = 2500;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_address;
    logic [31:0] cmd_writedata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_readdata;
    logic [15:0] master_address;
    logic        master_read, master_write, master_waitrequest;
    logic [31:0] master_writedata, master_readdata;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    csr_avalon_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .csr_clk_clk        (clk),
        .csr_clk_reset_reset(rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_address        (cmd_address),
        .cmd_writedata      (cmd_writedata),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_readdata       (rsp_readdata),
        .rsp_error          (rsp_error),
        .master_address     (master_address),
        .master_read        (master_read),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_readdata    (master_readdata),
        .master_waitrequest (master_waitrequest)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Transaction-level expectations: how many strobe cycles, and what comes back.
    function automatic bit exp_abort(input int nwait);
`ifdef CSR_INITIATOR_TIMEOUT_EN
        return nwait >= TO;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_strobes(input int nwait);
        return exp_abort(nwait) ? TO : nwait + 1;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic wr, input logic [31:0] rd, input int nwait);
        if (exp_abort(nwait)) return 32'hDEADC0DE;
        return wr ? 32'h0 : rd;
    endfunction

    // Starts and ends just after a falling edge.
    task automatic run_txn(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int nwait, input int hold);
        int cyc;
        logic [31:0] erd;
        erd = exp_rdata(wr, rd, nwait);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid     = 1'b1;
        cmd_write     = wr;
        cmd_address   = a;
        cmd_writedata = wd;
        @(negedge clk);
        cmd_valid     = 1'b0;
        cmd_write     = 1'($urandom);
        cmd_address   = 16'($urandom);
        cmd_writedata = $urandom;
        cyc = 0;
        while ((master_read || master_write) && cyc < BUDGET) begin
            cyc++;
            if (cyc <= 16 || cyc % 256 == 0) begin
                check("strobe_kind", 32'({master_read, master_write}), wr ? 32'd1 : 32'd2);
                check("master_address", 32'(master_address), 32'(a));
                if (wr) check("master_writedata", master_writedata, wd);
                check("rsp_valid_in_access", 32'(rsp_valid), 32'd0);
            end
            master_waitrequest = (cyc <= nwait);
            master_readdata    = master_waitrequest ? $urandom : rd;
            @(negedge clk);
        end
        master_waitrequest = 1'($urandom);
        master_readdata    = $urandom;
        check("strobe_cycles", 32'(cyc), 32'(exp_strobes(nwait)));
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_readdata", rsp_readdata, erd);
        check("rsp_error", 32'(rsp_error), 32'(exp_abort(nwait)));
        for (int h = 0; h < hold; h++) begin
            cmd_valid   = 1'b1;
            cmd_write   = 1'($urandom);
            cmd_address = 16'($urandom);
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_readdata", rsp_readdata, erd);
            check("hold_rsp_error", 32'(rsp_error), 32'(exp_abort(nwait)));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_strobes", 32'({master_read, master_write}), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        cmd_valid          = 1'b0;
        cmd_write          = 1'b0;
        cmd_address        = '0;
        cmd_writedata      = '0;
        rsp_ready          = 1'b0;
        master_readdata    = '0;
        master_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_readdata", rsp_readdata, 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_strobes", 32'({master_read, master_write}), 32'd0);
        check("rst_address", 32'(master_address), 32'd0);
        check("rst_writedata", master_writedata, 32'd0);

        run_txn(1'b0, 16'h0040, 32'h0, 32'h12345678, 0, 0);
        run_txn(1'b1, 16'h8004, 32'hA5A5A5A5, 32'h0, 3, 0);
        run_txn(1'b0, 16'h1234, 32'h0, 32'hCAFEF00D, 1, 5);
`ifdef CSR_INITIATOR_TIMEOUT_EN
        run_txn(1'b0, 16'h0100, 32'h0, 32'h11111111, TO + 5, 1);
        run_txn(1'b0, 16'h0104, 32'h0, 32'h22222222, TO - 1, 0);
        run_txn(1'b1, 16'h0108, 32'h33333333, 32'h0, TO, 0);
`else
        run_txn(1'b0, 16'h0200, 32'h0, 32'h5EED5EED, 2000, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            int r, nw;
            r = int'($urandom_range(0, 9));
            if (r < 5)      nw = 0;
            else if (r < 8) nw = int'($urandom_range(1, 4));
            else            nw = int'($urandom_range(TO - 2, TO + 2));
            run_txn(1'($urandom), 16'($urandom), $urandom, $urandom, nw, int'($urandom_range(0, 3)));
        end

        // Reset two cycles into a stalled read.
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 16'h0ABC;
        @(negedge clk);
        cmd_valid          = 1'b0;
        master_waitrequest = 1'b1;
        @(negedge clk);
        check("stall_read_high", 32'(master_read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_read", 32'(master_read), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        rst                = 1'b0;
        master_waitrequest = 1'b0;
        rsp_ready          = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_after_cmd_ready", 32'(cmd_ready), 32'd1);
            check("rst_after_address", 32'(master_address), 32'd0);
        end
        rsp_ready = 1'b0;
        run_txn(1'b0, 16'h0044, 32'h0, 32'h87654321, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
